// File: rtl/uart_rx_shift_if.sv
// Bus between the UART receiver and its consumer: oversample strobe, serial
// line and read acknowledge in; received byte and status flags out.
interface uart_rx_shift_if;
  logic       tick;
  logic       rx;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  // master is the side that feeds the line and consumes bytes
  modport master (
    output tick, rx, rd,
    input  data, valid, frame_err, overrun, busy
  );

  // slave is the receiver itself
  modport slave (
    input  tick, rx, rd,
    output data, valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_shift.sv
// Oversampling UART receiver: 8N1 frames, mid-bit sampling, single-byte
// holding register with valid/overrun flags and a one-clk framing-error pulse.
module uart_rx_shift #(
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_shift_if.slave  bus
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;
  logic          r_busy;
  logic          w_rx_s;

  assign w_rx_s = r_sync2;

  // Flops reset to idle-high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (bus.rd) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (bus.tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state <= START;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          START: begin
            if (r_cnt == HALF_LAST) begin
              r_cnt <= '0;
              if (!w_rx_s) begin
                r_state   <= DATA;
                r_bit_idx <= '0;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          DATA: begin
            if (r_cnt == FULL_LAST) begin
              r_cnt     <= '0;
              r_shift   <= {w_rx_s, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7)
                r_state <= STOP;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          STOP: begin
            if (r_cnt == FULL_LAST) begin
              r_cnt <= '0;
              if (w_rx_s) begin
                // a same-cycle rd consumes the old byte, so no overrun then
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !bus.rd)
                  r_overrun <= 1'b1;
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= BREAK;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          BREAK: begin
            if (w_rx_s) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = r_busy;

endmodule
